// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the MULT/MULTU sequencer and its bench.
// Latency constants are counted from the edge that samples start up to the done cycle.
package mul_seq_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    localparam logic [2:0] ALU_OP_ADD = 3'b010;
    // alu_unit "sub" is A + ~B with no carry-in; neg(x) is therefore A=1, B=x.
    localparam logic [2:0] ALU_OP_SUB = 3'b110;

    localparam int MUL_LAT_SIGNED   = 37;
    localparam int MUL_LAT_UNSIGNED = 33;

    typedef enum logic [2:0] {
        IDLE,
        PREP_A,
        PREP_B,
        ITER,
        FIX_LO,
        FIX_HI,
        DONE
    } state_e;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Issue/result bundle between decode/stall logic (master) and the multiply sequencer (slave).
// start/op_signed/a/b are sampled only while busy is low; hi/lo are valid from the done pulse.
interface mul_seq_ctrl_if;
    import mul_seq_pkg::*;

    logic              start;
    logic              op_signed;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (output start, op_signed, a, b, input busy, done, hi, lo);
    modport slave  (input start, op_signed, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/alu_unit.sv
// 32-bit integer ALU: and/or/add/sub with carry-out from the 33-bit sum.
// Purely combinational, zero latency; no flow control.
// Sub is A + ~B without carry-in, so callers build two's complement themselves.
module alu_unit
    import mul_seq_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  alu_op_i,
    output logic [31:0] result_o,
    output logic        carry_out_o
);

    logic [32:0] sum;

    always_comb begin
        sum         = '0;
        result_o    = '0;
        carry_out_o = 1'b0;
        case (alu_op_i)
            3'b000: result_o = a_i & b_i;
            3'b001: result_o = a_i | b_i;
            ALU_OP_ADD: begin
                sum         = {1'b0, a_i} + {1'b0, b_i};
                result_o    = sum[31:0];
                carry_out_o = sum[32];
            end
            ALU_OP_SUB: begin
                sum         = {1'b0, a_i} + {1'b0, ~b_i};
                result_o    = sum[31:0];
                carry_out_o = sum[32];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// MIPS MULT/MULTU shift-add sequencer driving one alu_unit; MUL_SIGNED_EN adds signed support.
// Fixed latency: done in cycle 37 (33 without MUL_SIGNED_EN) after the start-sampling edge.
// No queueing: start is ignored while busy, including the done cycle; hi/lo hold until the next done.
module mul_seq_ctrl
    import mul_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mul_seq_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] p_hi_q, p_hi_d;
    logic [DATA_W-1:0] p_lo_q, p_lo_d;
    logic [DATA_W-1:0] hi_q, lo_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a, alu_b, alu_y;
    logic [2:0]        alu_op;
    logic              alu_co;
`ifdef MUL_SIGNED_EN
    logic              os_q, os_d;
    logic              sign_q, sign_d;
    logic              c_q, c_d;
`endif

    alu_unit u_alu (
        .a_i        (alu_a),
        .b_i        (alu_b),
        .alu_op_i   (alu_op),
        .result_o   (alu_y),
        .carry_out_o(alu_co)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        cnt_d   = cnt_q;
        alu_a   = p_hi_q;
        alu_b   = mcand_q;
        alu_op  = ALU_OP_ADD;
`ifdef MUL_SIGNED_EN
        os_d    = os_q;
        sign_d  = sign_q;
        c_d     = c_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mcand_d = bus.a;
                    p_lo_d  = bus.b;
                    p_hi_d  = '0;
                    cnt_d   = '0;
`ifdef MUL_SIGNED_EN
                    os_d    = bus.op_signed;
                    sign_d  = bus.op_signed & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
                    state_d = PREP_A;
`else
                    state_d = ITER;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            PREP_A: begin
                alu_a  = DATA_W'(1);
                alu_b  = mcand_q;
                alu_op = ALU_OP_SUB;
                if (os_q && mcand_q[DATA_W-1]) mcand_d = alu_y;
                state_d = PREP_B;
            end
            PREP_B: begin
                alu_a  = DATA_W'(1);
                alu_b  = p_lo_q;
                alu_op = ALU_OP_SUB;
                if (os_q && p_lo_q[DATA_W-1]) p_lo_d = alu_y;
                p_hi_d  = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
`endif
            ITER: begin
                if (p_lo_q[0]) {p_hi_d, p_lo_d} = {alu_co, alu_y, p_lo_q[DATA_W-1:1]};
                else           {p_hi_d, p_lo_d} = {1'b0, p_hi_q, p_lo_q[DATA_W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef MUL_SIGNED_EN
                    state_d = FIX_LO;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef MUL_SIGNED_EN
            // 64-bit negate split in two: low word 1+~lo, its carry feeds ~hi+c.
            FIX_LO: begin
                alu_a  = DATA_W'(1);
                alu_b  = p_lo_q;
                alu_op = ALU_OP_SUB;
                if (sign_q) begin
                    p_lo_d = alu_y;
                    c_d    = alu_co;
                end else begin
                    c_d    = 1'b0;
                end
                state_d = FIX_HI;
            end
            FIX_HI: begin
                alu_a  = {{(DATA_W-1){1'b0}}, c_q};
                alu_b  = p_hi_q;
                alu_op = ALU_OP_SUB;
                if (sign_q) p_hi_d = alu_y;
                state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MUL_SIGNED_EN
            os_q    <= 1'b0;
            sign_q  <= 1'b0;
            c_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            cnt_q   <= cnt_d;
`ifdef MUL_SIGNED_EN
            os_q    <= os_d;
            sign_q  <= sign_d;
            c_q     <= c_d;
`endif
            if (state_d == DONE) begin
                hi_q <= p_hi_d;
                lo_q <= p_lo_d;
            end
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
